// File: rtl/i4004_fetch.sv
`default_nettype none
// ============================================================================
// i4004_fetch : 4004-style phase sequencer, ROM fetch, PC and 3-level stack.
// Rev 1.0
// ============================================================================
module i4004_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dbus_in,
  output logic [3:0] dbus_out,
  output logic       dbus_oe,
  output logic       sync,
  output logic       cm_rom,
  output logic       cl_rom,
  output logic       instr_valid,
  output logic [3:0] instr_opr,
  output logic [3:0] instr_opa,
  output logic       instr_second,
  input  logic       br_take,
  input  logic [7:0] src_data
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t      phase_q;
  logic [11:0] pc_q, pc_d, pc_inc;
  logic [3:0]  opr_q, opa_q, fopr_q, fopa_q;
  logic        second_q, second_d;
  logic [11:0] stk_q [0:2];
  logic [1:0]  sp_q, sp_inc, sp_dec;
  logic        push, pop;
  logic        cl_q;
  logic        valid_q, isec_q;
  logic [3:0]  iopr_q, iopa_q;
  logic        is_src, is_io, is_two;

  assign is_src = !second_q && (opr_q == 4'h2) && opa_q[0];
  assign is_io  = !second_q && (opr_q == 4'hE);
  assign is_two = !second_q && ((opr_q == 4'h1) || (opr_q == 4'h4) || (opr_q == 4'h5) ||
                                (opr_q == 4'h7) || ((opr_q == 4'h2) && !opa_q[0]));

  assign pc_inc = pc_q + 12'd1;
  assign sp_inc = (sp_q == 2'd2) ? 2'd0 : sp_q + 2'd1;
  assign sp_dec = (sp_q == 2'd0) ? 2'd2 : sp_q - 2'd1;

  // Next PC is resolved at X3 from the first word (saved in fopr/fopa) and the current word.
  always_comb begin
    pc_d     = pc_inc;
    push     = 1'b0;
    pop      = 1'b0;
    second_d = 1'b0;
    if (second_q) begin
      case (fopr_q)
        4'h4: pc_d = {fopa_q, opr_q, opa_q};
        4'h5: begin
          push = 1'b1;
          pc_d = {fopa_q, opr_q, opa_q};
        end
        4'h1, 4'h7: if (br_take) pc_d = {pc_q[11:8], opr_q, opa_q};
        default: ;
      endcase
    end else begin
      second_d = is_two;
      if (opr_q == 4'hC) begin
        pop  = 1'b1;
        pc_d = stk_q[sp_dec];
      end
    end
  end

  always_ff @(posedge clk) begin
    cl_q <= rst;
    if (rst) begin
      phase_q  <= PH_X3;
      pc_q     <= '0;
      opr_q    <= '0;
      opa_q    <= '0;
      fopr_q   <= '0;
      fopa_q   <= '0;
      second_q <= 1'b0;
      sp_q     <= '0;
      valid_q  <= 1'b0;
      isec_q   <= 1'b0;
      iopr_q   <= '0;
      iopa_q   <= '0;
      for (int i = 0; i < 3; i++) stk_q[i] <= '0;
    end else begin
      phase_q <= phase_t'(phase_q + 3'd1);
      valid_q <= 1'b0;
      case (phase_q)
        PH_M1: opr_q <= dbus_in;
        PH_M2: begin
          opa_q   <= dbus_in;
          valid_q <= 1'b1;
          iopr_q  <= opr_q;
          iopa_q  <= dbus_in;
          isec_q  <= second_q;
        end
        PH_X3: begin
          // cl_q marks the X3 straight out of reset: no word was fetched, so nothing executes.
          if (!cl_q) begin
            pc_q     <= pc_d;
            second_q <= second_d;
            if (!second_q) begin
              fopr_q <= opr_q;
              fopa_q <= opa_q;
            end
            if (push) begin
              stk_q[sp_q] <= pc_inc;
              sp_q        <= sp_inc;
            end
            if (pop) sp_q <= sp_dec;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dbus_out = 4'h0;
    dbus_oe  = 1'b0;
    if (!rst) begin
      case (phase_q)
        PH_A1: begin dbus_out = pc_q[3:0];  dbus_oe = 1'b1; end
        PH_A2: begin dbus_out = pc_q[7:4];  dbus_oe = 1'b1; end
        PH_A3: begin dbus_out = pc_q[11:8]; dbus_oe = 1'b1; end
        PH_X2: if (is_src) begin dbus_out = src_data[7:4]; dbus_oe = 1'b1; end
        PH_X3: if (is_src) begin dbus_out = src_data[3:0]; dbus_oe = 1'b1; end
        default: ;
      endcase
    end
  end

  assign sync   = (phase_q == PH_X3);
  assign cm_rom = (phase_q == PH_A3) || ((phase_q == PH_M2) && is_io) ||
                  ((phase_q == PH_X2) && is_src);
  assign cl_rom = cl_q;

  assign instr_valid  = valid_q;
  assign instr_opr    = iopr_q;
  assign instr_opa    = iopa_q;
  assign instr_second = isec_q;

endmodule
`default_nettype wire

// File: tb/tb_i4004_fetch.sv
`default_nettype none
// tb_i4004_fetch : directed and randomized checks of i4004_fetch against an
// instruction-level model; the ROM answers the address the DUT actually drives.
module tb_i4004_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dbus_in = 4'h0;
  logic       br_take = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic [3:0] dbus_out;
  logic       dbus_oe, sync, cm_rom, cl_rom, instr_valid, instr_second;
  logic [3:0] instr_opr, instr_opa;

  always #5 clk = ~clk;

  i4004_fetch dut (
    .clk(clk), .rst(rst), .dbus_in(dbus_in), .dbus_out(dbus_out), .dbus_oe(dbus_oe),
    .sync(sync), .cm_rom(cm_rom), .cl_rom(cl_rom), .instr_valid(instr_valid),
    .instr_opr(instr_opr), .instr_opa(instr_opa), .instr_second(instr_second),
    .br_take(br_take), .src_data(src_data)
  );

  int n_chk = 0, n_err = 0;
  logic [7:0] rom [0:4095];

  logic [2:0]  m_ph;
  logic [11:0] m_pc;
  logic [11:0] m_stk [0:2];
  int          m_ptr;
  logic        m_sec, m_skip, m_cl;
  logic [3:0]  m_opr, m_opa, m_fopr, m_fopa;
  logic        h_val, h_sec;
  logic [3:0]  h_opr, h_opa;

  logic [11:0] raddr = 12'h000;
  int          bt_fix = -1, src_fix = -1;
  logic        chk_en = 1'b0;
  logic [11:0] obs_addr;
  logic [7:0]  obs_cm;
  logic [3:0]  obs_bus [0:7];
  logic [3:0]  obs_opr, obs_opa;
  logic        obs_sec, obs_cl;
  logic [11:0] addrs [0:15];

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 3'd7; m_pc = '0; m_ptr = 0; m_sec = 0; m_skip = 1; m_cl = 1;
    m_opr = 0; m_opa = 0; m_fopr = 0; m_fopa = 0;
    h_val = 0; h_sec = 0; h_opr = 0; h_opa = 0;
    for (int i = 0; i < 3; i++) m_stk[i] = '0;
  endtask

  // Whole-instruction semantics applied at the X3 boundary.
  task automatic execute(input logic bt);
    logic [11:0] nxt;
    nxt = m_pc + 12'd1;
    if (m_sec) begin
      m_sec = 0;
      if (m_fopr == 4'h4) nxt = {m_fopa, m_opr, m_opa};
      else if (m_fopr == 4'h5) begin
        m_stk[m_ptr] = nxt;
        m_ptr = (m_ptr + 1) % 3;
        nxt = {m_fopa, m_opr, m_opa};
      end else if ((m_fopr == 4'h1 || m_fopr == 4'h7) && bt) nxt = {m_pc[11:8], m_opr, m_opa};
    end else begin
      if (m_opr == 4'hC) begin
        m_ptr = (m_ptr + 2) % 3;
        nxt = m_stk[m_ptr];
      end
      if (m_opr inside {4'h1, 4'h4, 4'h5, 4'h7} || (m_opr == 4'h2 && !m_opa[0])) begin
        m_sec = 1; m_fopr = m_opr; m_fopa = m_opa;
      end
    end
    m_pc = nxt;
  endtask

  task automatic step(input logic r);
    logic       bt, e_src, e_oe, e_cm;
    logic [3:0] e_out;
    logic [7:0] rd;
    @(negedge clk);
    rst = r;
    rd = rom[raddr];
    if (m_ph == 3'd3)      dbus_in = rd[7:4];
    else if (m_ph == 3'd4) dbus_in = rd[3:0];
    else                   dbus_in = 4'($urandom_range(15, 0));
    src_data = (src_fix >= 0) ? 8'(src_fix) : 8'($urandom_range(255, 0));
    br_take  = (m_ph == 3'd7 && bt_fix >= 0) ? bt_fix[0] : 1'($urandom_range(1, 0));
    bt = br_take;
    #1;
    e_src = !m_sec && m_opr == 4'h2 && m_opa[0];
    e_oe = 0; e_out = 0;
    if (!r) begin
      if (m_ph <= 3'd2) begin e_oe = 1; e_out = 4'(m_pc >> (4 * m_ph)); end
      else if (m_ph == 3'd6 && e_src) begin e_oe = 1; e_out = src_data[7:4]; end
      else if (m_ph == 3'd7 && e_src) begin e_oe = 1; e_out = src_data[3:0]; end
    end
    e_cm = (m_ph == 3'd2) || (m_ph == 3'd4 && !m_sec && m_opr == 4'hE) || (m_ph == 3'd6 && e_src);
    if (chk_en) begin
      check("sync", sync, m_ph == 3'd7);
      check("cm_rom", cm_rom, e_cm);
      check("cl_rom", cl_rom, m_cl);
      check("dbus_oe", dbus_oe, e_oe);
      check("dbus_out", dbus_out, e_out);
      check("instr_valid", instr_valid, h_val);
      check("instr_opr", instr_opr, h_opr);
      check("instr_opa", instr_opa, h_opa);
      check("instr_second", instr_second, h_sec);
    end
    obs_cm[m_ph] = cm_rom;
    obs_bus[m_ph] = dbus_out;
    obs_cl = cl_rom;
    if (!r && m_ph <= 3'd2) begin
      obs_addr[4*m_ph +: 4] = dbus_out;
      raddr[4*m_ph +: 4] = dbus_out;
    end
    if (m_ph == 3'd5) begin obs_opr = instr_opr; obs_opa = instr_opa; obs_sec = instr_second; end
    if (r) model_reset();
    else begin
      m_cl = 0;
      case (m_ph)
        3'd3: m_opr = rom[m_pc][7:4];
        3'd4: begin
          m_opa = rom[m_pc][3:0];
          h_val = 1; h_opr = m_opr; h_opa = m_opa; h_sec = m_sec;
        end
        3'd5: h_val = 0;
        3'd7: begin
          if (!m_skip) execute(bt);
          m_skip = 0;
        end
        default: ;
      endcase
      m_ph = m_ph + 3'd1;
    end
  endtask

  task automatic cycle();
    for (int i = 0; i < 8; i++) step(1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
    step(1'b0);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  initial begin
    model_reset();
    step(1'b1); step(1'b1);
    chk_en = 1'b1;

    // Reset release, all-zero ROM
    clear_rom();
    do_reset(3);
    check("cl_after_release", obs_cl, 1);
    cycle();
    check("t1_addr0", obs_addr, 12'h000);
    check("t1_opr", obs_opr, 0);
    check("t1_opa", obs_opa, 0);
    check("t1_cl_low", obs_cl, 0);
    cycle();
    check("t1_addr1", obs_addr, 12'h001);

    // JUN 0x4A 0x12
    clear_rom(); rom[0] = 8'h4A; rom[1] = 8'h12;
    do_reset(2);
    cycle();
    check("jun_w1_second", obs_sec, 0);
    check("jun_w1_opr", obs_opr, 4'h4);
    check("jun_w1_opa", obs_opa, 4'hA);
    cycle();
    check("jun_w2_second", obs_sec, 1);
    cycle();
    check("jun_target", obs_addr, 12'hA12);

    // JMS 0x100 from 0x010, BBL returns to 0x012
    clear_rom(); rom[0] = 8'h40; rom[1] = 8'h10;
    rom[12'h010] = 8'h51; rom[12'h011] = 8'h00; rom[12'h100] = 8'hC0;
    do_reset(2);
    for (int i = 0; i < 6; i++) begin cycle(); addrs[i] = obs_addr; end
    check("jms_target", addrs[4], 12'h100);
    check("bbl_return", addrs[5], 12'h012);

    // Four nested JMS then four BBL: the 4th pop sees the 4th push
    clear_rom(); rom[0] = 8'h42; rom[1] = 8'h00;
    rom[12'h200] = 8'h53; rom[12'h300] = 8'h54; rom[12'h400] = 8'h55; rom[12'h500] = 8'h56;
    rom[12'h600] = 8'hC0; rom[12'h502] = 8'hC0; rom[12'h402] = 8'hC0; rom[12'h302] = 8'hC0;
    do_reset(2);
    for (int i = 0; i < 15; i++) begin cycle(); addrs[i] = obs_addr; end
    check("nest_deepest", addrs[10], 12'h600);
    check("nest_ret1", addrs[11], 12'h502);
    check("nest_ret2", addrs[12], 12'h402);
    check("nest_ret3", addrs[13], 12'h302);
    check("nest_ret4", addrs[14], 12'h502);

    // JCN at the page end, taken and not taken
    clear_rom(); rom[0] = 8'h40; rom[1] = 8'hFE; rom[12'h0FE] = 8'h14; rom[12'h0FF] = 8'h34;
    for (int t = 1; t >= 0; t--) begin
      bt_fix = t;
      do_reset(2);
      for (int i = 0; i < 5; i++) begin cycle(); addrs[i] = obs_addr; end
      check("jcn_second_addr", addrs[3], 12'h0FF);
      check(t ? "jcn_taken" : "jcn_not_taken", addrs[4], t ? 12'h034 : 12'h100);
    end
    bt_fix = -1;

    // SRC with src_data 0xA5
    clear_rom(); rom[0] = 8'h21; src_fix = 8'hA5;
    do_reset(2);
    cycle();
    check("src_cm", obs_cm, 8'h44);
    check("src_x2", obs_bus[6], 4'hA);
    check("src_x3", obs_bus[7], 4'h5);
    src_fix = -1;

    // I/O word, then FIM whose second word looks like I/O
    clear_rom(); rom[0] = 8'hE2;
    do_reset(2);
    cycle();
    check("io_cm", obs_cm, 8'h14);
    clear_rom(); rom[0] = 8'h20; rom[1] = 8'hE2;
    do_reset(2);
    cycle();
    check("fim_w1_cm", obs_cm, 8'h04);
    cycle();
    check("fim_w2_cm", obs_cm, 8'h04);

    // Randomized program with one mid-cycle reset
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom_range(255, 0));
    do_reset(2);
    for (int n = 0; n < 300; n++) begin
      cycle();
      if (n == 150) begin
        repeat ($urandom_range(6, 1)) step(1'b0);
        step(1'b1); step(1'b1); step(1'b0);
        cycle();
        check("rst_mid_addr", obs_addr, 12'h000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
